// File: rtl/fp_add_status_stage.sv
// Registered output stage for the FP adder: 2-entry FIFO with result classification,
// sticky status flags and a saturating transfer counter. Define FP_STATUS_FTZ_EN to flush denormals at the output.
module fp_add_status_stage #(
    parameter int XLEN  = 32,
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [2:0]       out_class,
    output logic             sticky_ovf,
    output logic             sticky_unf,
    output logic             sticky_nan,
    input  logic             flag_clr,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [2:0] CLS_ZERO = 3'd0;
    localparam logic [2:0] CLS_NORM = 3'd1;
    localparam logic [2:0] CLS_DEN  = 3'd2;
    localparam logic [2:0] CLS_INF  = 3'd3;
    localparam logic [2:0] CLS_NAN  = 3'd4;

    logic [EXP_W-1:0] exp_w;
    logic [MAN_W-1:0] man_w;
    logic [2:0]       in_class;

    // Slot 0 is always the head; slot 1 only holds data when count is 2.
    logic [XLEN-1:0]  data0_q, data0_d, data1_q, data1_d;
    logic [2:0]       cls0_q, cls0_d, cls1_q, cls1_d;
    logic [1:0]       count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d, nan_q, nan_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
    logic             push, pop;

    assign exp_w = in_result[XLEN-2 -: EXP_W];
    assign man_w = in_result[MAN_W-1:0];

    always_comb begin
        in_class = CLS_NORM;
        if (&exp_w) begin
            in_class = (|man_w) ? CLS_NAN : CLS_INF;
        end else if (exp_w == '0) begin
            in_class = (|man_w) ? CLS_DEN : CLS_ZERO;
        end
    end

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        data0_d = data0_q;
        data1_d = data1_q;
        cls0_d  = cls0_q;
        cls1_d  = cls1_q;
        count_d = count_q;
        if (push && pop) begin
            // Only reachable at count 1: the new word replaces the departing head.
            data0_d = in_result;
            cls0_d  = in_class;
        end else if (pop) begin
            data0_d = data1_q;
            cls0_d  = cls1_q;
            count_d = count_q - 2'd1;
        end else if (push) begin
            if (count_q == 2'd0) begin
                data0_d = in_result;
                cls0_d  = in_class;
            end else begin
                data1_d = in_result;
                cls1_d  = in_class;
            end
            count_d = count_q + 2'd1;
        end
    end

    // A setting pop outranks a coincident clear.
    always_comb begin
        ovf_d    = (flag_clr ? 1'b0 : ovf_q) | (pop && cls0_q == CLS_INF);
        unf_d    = (flag_clr ? 1'b0 : unf_q) | (pop && cls0_q == CLS_DEN);
        nan_d    = (flag_clr ? 1'b0 : nan_q) | (pop && cls0_q == CLS_NAN);
        cnt_base = flag_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (pop && cnt_base != '1) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data0_q <= '0;
            data1_q <= '0;
            cls0_q  <= CLS_ZERO;
            cls1_q  <= CLS_ZERO;
            count_q <= 2'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            nan_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            data0_q <= data0_d;
            data1_q <= data1_d;
            cls0_q  <= cls0_d;
            cls1_q  <= cls1_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            nan_q   <= nan_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef FP_STATUS_FTZ_EN
    assign out_result = (cls0_q == CLS_DEN) ? {data0_q[XLEN-1], {(XLEN-1){1'b0}}} : data0_q;
`else
    assign out_result = data0_q;
`endif
    assign out_class  = cls0_q;
    assign sticky_ovf = ovf_q;
    assign sticky_unf = unf_q;
    assign sticky_nan = nan_q;
    assign xfer_cnt   = cnt_q;

endmodule

// File: tb/tb_fp_add_status_stage.sv
// Directed self-checking bench for fp_add_status_stage; a second instance with a
// 2-bit counter exercises counter saturation.
module tb_fp_add_status_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_result = '0;
    logic        out_ready = 1'b0;
    logic        flag_clr = 1'b0;

    logic        in_ready, out_valid, sticky_ovf, sticky_unf, sticky_nan;
    logic [31:0] out_result;
    logic [2:0]  out_class;
    logic [15:0] xfer_cnt;

    logic        s_in_ready, s_out_valid, s_ovf, s_unf, s_nan;
    logic [31:0] s_out_result;
    logic [2:0]  s_out_class;
    logic [1:0]  s_xfer_cnt;

    int n_cmp = 0;
    int n_err = 0;

`ifdef FP_STATUS_FTZ_EN
    localparam bit FTZ = 1'b1;
`else
    localparam bit FTZ = 1'b0;
`endif

    always #5 clk = ~clk;

    fp_add_status_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_class(out_class), .sticky_ovf(sticky_ovf),
        .sticky_unf(sticky_unf), .sticky_nan(sticky_nan), .flag_clr(flag_clr),
        .xfer_cnt(xfer_cnt)
    );

    fp_add_status_stage #(.CNT_W(2)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_result(in_result), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_result(s_out_result), .out_class(s_out_class), .sticky_ovf(s_ovf),
        .sticky_unf(s_unf), .sticky_nan(s_nan), .flag_clr(flag_clr),
        .xfer_cnt(s_xfer_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_flags;
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    initial begin
        // reset
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_result", out_result, 32'h0);
        chk("rst_out_class", {29'b0, out_class}, 32'd0);
        chk("rst_flags", {29'b0, sticky_ovf, sticky_unf, sticky_nan}, 32'd0);
        chk("rst_cnt", {16'b0, xfer_cnt}, 32'd0);

        // normal value passes through
        in_valid = 1'b1; in_result = 32'h40ECCCCD; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("norm_valid", {31'b0, out_valid}, 32'd1);
        chk("norm_result", out_result, 32'h40ECCCCD);
        chk("norm_class", {29'b0, out_class}, 32'd1);
        tick();
        chk("norm_valid_after", {31'b0, out_valid}, 32'd0);
        chk("norm_cnt", {16'b0, xfer_cnt}, 32'd1);
        chk("norm_flags", {29'b0, sticky_ovf, sticky_unf, sticky_nan}, 32'd0);

        // +0 and -0
        clear_flags();
        in_valid = 1'b1; in_result = 32'h00000000;
        tick();
        chk("pzero_class", {29'b0, out_class}, 32'd0);
        chk("pzero_result", out_result, 32'h00000000);
        in_result = 32'h80000000;
        tick();
        in_valid = 1'b0;
        chk("nzero_result", out_result, 32'h80000000);
        chk("nzero_class", {29'b0, out_class}, 32'd0);
        chk("zero_cnt_mid", {16'b0, xfer_cnt}, 32'd1);
        tick();
        chk("zero_cnt", {16'b0, xfer_cnt}, 32'd2);
        chk("zero_unf", {31'b0, sticky_unf}, 32'd0);
        chk("zero_empty", {31'b0, out_valid}, 32'd0);

        // infinity, NaN, clear coinciding with a setting pop
        clear_flags();
        in_valid = 1'b1; in_result = 32'h7F800000;
        tick();
        chk("inf_class", {29'b0, out_class}, 32'd3);
        in_result = 32'h7FC00000;
        tick();
        in_valid = 1'b0;
        chk("nan_class", {29'b0, out_class}, 32'd4);
        chk("inf_flags", {29'b0, sticky_ovf, sticky_unf, sticky_nan}, 32'b100);
        tick();
        chk("nan_flags", {29'b0, sticky_ovf, sticky_unf, sticky_nan}, 32'b101);
        chk("infnan_cnt", {16'b0, xfer_cnt}, 32'd2);
        in_valid = 1'b1; in_result = 32'h7F800000;
        tick();
        in_valid = 1'b0;
        chk("inf2_class", {29'b0, out_class}, 32'd3);
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
        chk("clr_pop_flags", {29'b0, sticky_ovf, sticky_unf, sticky_nan}, 32'b100);
        chk("clr_pop_cnt", {16'b0, xfer_cnt}, 32'd1);

        // denormals
        clear_flags();
        in_valid = 1'b1; in_result = 32'h00000001;
        tick();
        in_valid = 1'b0;
        chk("den_class", {29'b0, out_class}, 32'd2);
        chk("den_result", out_result, FTZ ? 32'h00000000 : 32'h00000001);
        tick();
        chk("den_flags", {29'b0, sticky_ovf, sticky_unf, sticky_nan}, 32'b010);
        in_valid = 1'b1; in_result = 32'h80000001;
        tick();
        in_valid = 1'b0;
        chk("nden_result", out_result, FTZ ? 32'h80000000 : 32'h80000001);
        chk("nden_class", {29'b0, out_class}, 32'd2);
        tick();

        // backpressure: A, B, C with out_ready low
        clear_flags();
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'h3F800000;
        tick();
        chk("bp_ready1", {31'b0, in_ready}, 32'd1);
        in_result = 32'h40000000;
        tick();
        chk("bp_ready2", {31'b0, in_ready}, 32'd0);
        chk("bp_head_a", out_result, 32'h3F800000);
        in_result = 32'h40400000;
        tick();
        chk("bp_ready3", {31'b0, in_ready}, 32'd0);
        chk("bp_hold_a", out_result, 32'h3F800000);
        chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b1;
        tick();
        chk("bp_head_b", out_result, 32'h40000000);
        chk("bp_ready4", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_head_c", out_result, 32'h40400000);
        chk("bp_valid_c", {31'b0, out_valid}, 32'd1);
        tick();
        chk("bp_empty", {31'b0, out_valid}, 32'd0);
        chk("bp_cnt", {16'b0, xfer_cnt}, 32'd3);
        chk("bp_cnt_small", {30'b0, s_xfer_cnt}, 32'd3);

        // counter saturation on the narrow instance, then reset with a full FIFO
        in_valid = 1'b1; in_result = 32'h7F800000;
        tick();
        in_valid = 1'b0;
        tick();
        chk("sat_cnt_small", {30'b0, s_xfer_cnt}, 32'd3);
        chk("sat_cnt", {16'b0, xfer_cnt}, 32'd4);
        chk("sat_ovf", {31'b0, sticky_ovf}, 32'd1);
        out_ready = 1'b0;
        in_valid = 1'b1; in_result = 32'h3F800000;
        tick();
        in_result = 32'h40000000;
        tick();
        in_valid = 1'b0;
        chk("full_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_valid", {31'b0, out_valid}, 32'd0);
        chk("mrst_ready", {31'b0, in_ready}, 32'd1);
        chk("mrst_flags", {29'b0, sticky_ovf, sticky_unf, sticky_nan}, 32'd0);
        chk("mrst_cnt", {16'b0, xfer_cnt}, 32'd0);
        chk("mrst_result", out_result, 32'h0);
        chk("mrst_class", {29'b0, out_class}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
